// File: rtl/squid_decoder_if.sv
// Block-in / weight-out stream bundle for the SQUID decoder.
// The master side produces blocks and accepts weights; the slave side is the decoder.
interface squid_decoder_if #(
  parameter int W_W     = 6,
  parameter int CODE_W  = 4,
  parameter int N_CODES = 4
);
  localparam int IDX_W = $clog2(2 * N_CODES);

  logic                        pp_valid;
  logic                        pp_ready;
  logic [CODE_W*N_CODES-1:0]   pp_data;
  logic                        w_valid;
  logic                        w_ready;
  logic [W_W-1:0]              w_data;
  logic [IDX_W-1:0]            w_idx;
  logic                        w_last;

  modport master (
    output pp_valid, pp_data, w_ready,
    input  pp_ready, w_valid, w_data, w_idx, w_last
  );

  modport slave (
    input  pp_valid, pp_data, w_ready,
    output pp_ready, w_valid, w_data, w_idx, w_last
  );
endinterface

// File: rtl/squid_decoder.sv
// SQUID block decompressor: four codebook codes expand into eight weights, one per beat.
// Optional completed-block counter on blk_cnt when SQUID_DEC_CNT_EN is defined.
module squid_decoder #(
  parameter int W_W     = 6,
  parameter int CODE_W  = 4,
  parameter int N_CODES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cb_wr_en,
  input  logic [CODE_W-1:0]    cb_wr_addr,
  input  logic [2*W_W-1:0]     cb_wr_data,
  squid_decoder_if.slave       bus,
  output logic                 busy
`ifdef SQUID_DEC_CNT_EN
  ,
  output logic [15:0]          blk_cnt
`endif
);
  localparam int CB_DEPTH = 2 ** CODE_W;
  localparam int PP_W     = CODE_W * N_CODES;
  localparam int N_W      = 2 * N_CODES;
  localparam int IDX_W    = $clog2(N_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_W - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state_q, state_d;
  logic [2*W_W-1:0]    cb [CB_DEPTH];
  logic [PP_W-1:0]     act_pp, hold_pp;
  logic [IDX_W-1:0]    idx;
  logic                hold_full;
  logic                pp_hs, w_hs, last_beat;
  logic [CODE_W-1:0]   cur_code;
  logic [2*W_W-1:0]    cur_entry;

  assign pp_hs     = bus.pp_valid & bus.pp_ready;
  assign w_hs      = bus.w_valid & bus.w_ready;
  assign last_beat = w_hs && (idx == LAST_IDX);
  assign cur_code  = act_pp[int'(idx[IDX_W-1:1])*CODE_W +: CODE_W];
  assign cur_entry = cb[cur_code];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A drained hold slot or a same-cycle arrival keeps the stream gapless.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pp_hs) state_d = STREAM;
      STREAM:  if (last_beat && !hold_full && !pp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.pp_ready = !hold_full;
    busy         = (state_q == STREAM) || hold_full;
    bus.w_valid  = 1'b0;
    bus.w_data   = '0;
    bus.w_idx    = '0;
    bus.w_last   = 1'b0;
    if (state_q == STREAM) begin
      bus.w_valid = 1'b1;
      bus.w_data  = idx[0] ? cur_entry[2*W_W-1:W_W] : cur_entry[W_W-1:0];
      bus.w_idx   = idx;
      bus.w_last  = (idx == LAST_IDX);
    end
  end

  // Hold captures any accepted block that did not directly reload the active slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_pp    <= '0;
      hold_pp   <= '0;
      idx       <= '0;
      hold_full <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        if (pp_hs) begin
          act_pp <= bus.pp_data;
          idx    <= '0;
        end
      end else begin
        if (w_hs) begin
          if (idx != LAST_IDX) begin
            idx <= idx + 1'b1;
          end else if (hold_full) begin
            act_pp    <= hold_pp;
            hold_full <= 1'b0;
            idx       <= '0;
          end else if (pp_hs) begin
            act_pp <= bus.pp_data;
            idx    <= '0;
          end
        end
        if (pp_hs && !last_beat) begin
          hold_pp   <= bus.pp_data;
          hold_full <= 1'b1;
        end
      end
    end
  end

  // Writes are dropped while busy so an accepted block decodes against a frozen codebook.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CB_DEPTH; k++) cb[k] <= '0;
    end else if (cb_wr_en && !busy) begin
      cb[cb_wr_addr] <= cb_wr_data;
    end
  end

`ifdef SQUID_DEC_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      blk_cnt <= '0;
    else if (w_hs && bus.w_last)     blk_cnt <= blk_cnt + 16'd1;
  end
`endif
endmodule
